// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the inst/data sram arbiter.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_DATA,
    D_ADDR,
    D_DATA
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_INST,
    SEL_DATA
  } req_sel_e;

  // kseg0/kseg1 are tagged by the top two address bits; mapping clears the top three.
  localparam logic [1:0]  KSEG01_TAG    = 2'b10;
  localparam int unsigned KSEG_CLR_BITS = 3;

  function automatic req_sel_e pick_requester(input logic inst_pend,
                                              input logic data_pend,
                                              input logic data_first);
    if (data_pend && (data_first || !inst_pend)) return SEL_DATA;
    if (inst_pend) return SEL_INST;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Like-sram memory port shared by the arbiter (master) and the bus bridge (slave).
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_req;
  logic                  mem_wr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_addr_map.sv
// Combinational virtual-to-physical mapping: kseg0/kseg1 fold onto low physical memory.
module sram_addr_map
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] vaddr,
  output logic [ADDR_W-1:0] paddr
);

  always_comb begin
    paddr = vaddr;
    if (vaddr[ADDR_W-1 -: 2] == KSEG01_TAG) paddr[ADDR_W-1 -: KSEG_CLR_BITS] = '0;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the CPU inst/data sram requests onto one like-sram memory port,
// one transaction at a time. Optional kseg mapping: SRAM_ARB_KSEG_MAP_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DATA_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_en,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                i_stall,
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                d_stall,
  input  logic                flush,
  sram_arbiter_if.master      mem
);

  arb_state_e          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wr_q, mem_wr_d;
  logic [DATA_W/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                inst_done_q, inst_done_d;
  logic                data_done_q, data_done_d;
  logic                kill_q, kill_d;

  req_sel_e            sel;
  logic [ADDR_W-1:0]   req_addr;
  logic [ADDR_W-1:0]   req_paddr;

  assign i_stall = kill_q | (inst_en & ~inst_done_q);
  assign d_stall = kill_q | (data_en & ~data_done_q);

  assign sel = pick_requester(inst_en & ~inst_done_q & ~flush,
                              data_en & ~data_done_q & ~flush,
                              DATA_FIRST != 0);
  assign req_addr = (sel == SEL_DATA) ? data_addr : inst_addr;

`ifdef SRAM_ARB_KSEG_MAP_EN
  sram_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
    .vaddr (req_addr),
    .paddr (req_paddr)
  );
`else
  assign req_paddr = req_addr;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = inst_done_q;
    data_done_d  = data_done_q;
    kill_d       = kill_q;

    if ((!i_stall && !d_stall) || flush) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
    end
    if (flush && state_q != IDLE) kill_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sel == SEL_DATA) begin
          state_d     = D_ADDR;
          mem_req_d   = 1'b1;
          mem_wr_d    = |data_wen;
          mem_wstrb_d = data_wen;
          mem_addr_d  = req_paddr;
          mem_wdata_d = data_wdata;
        end else if (sel == SEL_INST) begin
          state_d     = I_ADDR;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_wstrb_d = '0;
          mem_addr_d  = req_paddr;
          mem_wdata_d = '0;
        end
      end
      I_ADDR, D_ADDR: begin
        if (mem.mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = (state_q == I_ADDR) ? I_DATA : D_DATA;
        end
      end
      I_DATA: begin
        if (mem.mem_data_ok) begin
          inst_rdata_d = mem.mem_rdata;
          if (!kill_q && !flush) inst_done_d = 1'b1;
          kill_d  = 1'b0;
          state_d = IDLE;
        end
      end
      D_DATA: begin
        // A kill drained here also overrides a kill raised by a same-cycle flush.
        if (mem.mem_data_ok) begin
          if (!mem_wr_q) data_rdata_d = mem.mem_rdata;
          if (!kill_q && !flush) data_done_d = 1'b1;
          kill_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      kill_q       <= kill_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign inst_rdata    = inst_rdata_q;
  assign data_rdata    = data_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one DUT with data priority, one with instruction priority.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        flush;

  logic [31:0] inst_rdata, data_rdata, inst_rdata2, data_rdata2;
  logic        i_stall, d_stall, i_stall2, d_stall2;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if2 ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1)) u_dut (
    .clk(clk), .rst(rst_n),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .d_stall(d_stall), .flush(flush), .mem(mem_if)
  );

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(0)) u_dut_ifirst (
    .clk(clk), .rst(rst_n),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata2), .i_stall(i_stall2),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata2), .d_stall(d_stall2), .flush(flush), .mem(mem_if2)
  );

`ifdef SRAM_ARB_KSEG_MAP_EN
  localparam logic [31:0] FETCH_PA  = 32'h1FC0_0000;
  localparam logic [31:0] FETCH_PA4 = 32'h1FC0_0004;
  localparam logic [31:0] STORE_PA  = 32'h0000_1000;
`else
  localparam logic [31:0] FETCH_PA  = 32'hBFC0_0000;
  localparam logic [31:0] FETCH_PA4 = 32'hBFC0_0004;
  localparam logic [31:0] STORE_PA  = 32'h8000_1000;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_en = 1'b0; inst_addr = '0;
    data_en = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    flush = 1'b0;
    mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b0; mem_if.mem_rdata = '0;
    mem_if2.mem_addr_ok = 1'b0; mem_if2.mem_data_ok = 1'b0; mem_if2.mem_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    inst_en = 1'b1; inst_addr = 32'hBFC0_0000;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    checks++; if (mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_if.mem_req); end
    checks++; if (mem_if.mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_if.mem_wr); end
    checks++; if (mem_if.mem_wstrb !== 4'h0) begin failures++; $display("FAIL reset_mem_wstrb got=%h exp=0", mem_if.mem_wstrb); end
    checks++; if (mem_if.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_if.mem_addr); end
    checks++; if (mem_if.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_if.mem_wdata); end
    checks++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", inst_rdata, data_rdata); end
    checks++; if (i_stall !== 1'b1) begin failures++; $display("FAIL reset_i_stall_en got=%b exp=1", i_stall); end
    inst_en = 1'b0;
    #1;
    checks++; if (i_stall !== 1'b0 || d_stall !== 1'b0) begin failures++; $display("FAIL reset_stalls got=%b%b exp=00", i_stall, d_stall); end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    apply_reset();
    cyc(); inst_en = 1'b1; inst_addr = 32'hBFC0_0000; #1;
    checks++; if (i_stall !== 1'b1 || mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_c0 got stall=%b req=%b exp 1/0", i_stall, mem_if.mem_req); end
    cyc(); mem_if.mem_addr_ok = 1'b1; #1;
    checks++; if (mem_if.mem_req !== 1'b1 || i_stall !== 1'b1) begin failures++; $display("FAIL fetch_c1 got req=%b stall=%b exp 1/1", mem_if.mem_req, i_stall); end
    checks++; if (mem_if.mem_addr !== FETCH_PA) begin failures++; $display("FAIL fetch_addr got=%h exp=%h", mem_if.mem_addr, FETCH_PA); end
    checks++; if (mem_if.mem_wr !== 1'b0 || mem_if.mem_wstrb !== 4'h0) begin failures++; $display("FAIL fetch_wr got wr=%b strb=%h exp 0/0", mem_if.mem_wr, mem_if.mem_wstrb); end
    cyc(); mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h2401_0001; #1;
    checks++; if (mem_if.mem_req !== 1'b0 || i_stall !== 1'b1) begin failures++; $display("FAIL fetch_c2 got req=%b stall=%b exp 0/1", mem_if.mem_req, i_stall); end
    cyc(); mem_if.mem_data_ok = 1'b0; mem_if.mem_rdata = '0; #1;
    checks++; if (i_stall !== 1'b0) begin failures++; $display("FAIL fetch_c3_stall got=%b exp=0", i_stall); end
    checks++; if (inst_rdata !== 32'h2401_0001) begin failures++; $display("FAIL fetch_rdata got=%h exp=24010001", inst_rdata); end
    cyc(); inst_en = 1'b0; #1;
    checks++; if (inst_rdata !== 32'h2401_0001 || mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_hold got rdata=%h req=%b exp 24010001/0", inst_rdata, mem_if.mem_req); end
  endtask

  task automatic test_both_pending();
    apply_reset();
    cyc();
    inst_en = 1'b1; inst_addr = 32'hBFC0_0004;
    data_en = 1'b1; data_wen = 4'hF; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF; #1;
    checks++; if (i_stall !== 1'b1 || d_stall !== 1'b1) begin failures++; $display("FAIL both_c0 got=%b%b exp=11", i_stall, d_stall); end
    cyc(); mem_if.mem_addr_ok = 1'b1; #1;
    checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_wr !== 1'b1 || mem_if.mem_wstrb !== 4'hF) begin failures++; $display("FAIL both_store_issue got req=%b wr=%b strb=%h exp 1/1/f", mem_if.mem_req, mem_if.mem_wr, mem_if.mem_wstrb); end
    checks++; if (mem_if.mem_addr !== STORE_PA || mem_if.mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL both_store_addr got=%h/%h exp=%h/deadbeef", mem_if.mem_addr, mem_if.mem_wdata, STORE_PA); end
    cyc(); mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h5555_5555; #1;
    cyc(); mem_if.mem_data_ok = 1'b0; #1;
    checks++; if (d_stall !== 1'b0 || i_stall !== 1'b1) begin failures++; $display("FAIL both_c3 got d=%b i=%b exp 0/1", d_stall, i_stall); end
    checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL both_store_rdata got=%h exp=0", data_rdata); end
    cyc(); mem_if.mem_addr_ok = 1'b1; #1;
    checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_wr !== 1'b0 || mem_if.mem_addr !== FETCH_PA4) begin failures++; $display("FAIL both_fetch_issue got req=%b wr=%b addr=%h exp 1/0/%h", mem_if.mem_req, mem_if.mem_wr, mem_if.mem_addr, FETCH_PA4); end
    checks++; if (d_stall !== 1'b0) begin failures++; $display("FAIL both_d_hold got=%b exp=0", d_stall); end
    cyc(); mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h8C22_0000; #1;
    cyc(); mem_if.mem_data_ok = 1'b0; #1;
    checks++; if (i_stall !== 1'b0 || d_stall !== 1'b0) begin failures++; $display("FAIL both_advance got=%b%b exp=00", i_stall, d_stall); end
    checks++; if (inst_rdata !== 32'h8C22_0000) begin failures++; $display("FAIL both_inst_rdata got=%h exp=8c220000", inst_rdata); end
    cyc(); #1;
    checks++; if (i_stall !== 1'b1 || d_stall !== 1'b1) begin failures++; $display("FAIL both_done_clear got=%b%b exp=11", i_stall, d_stall); end
    idle_inputs();
  endtask

  task automatic test_addr_ok_delay();
    apply_reset();
    cyc(); data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_2000; #1;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h0000_2000 || mem_if.mem_wr !== 1'b0) begin failures++; $display("FAIL delay_hold%0d got req=%b addr=%h wr=%b exp 1/00002000/0", k, mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wr); end
    end
    cyc(); mem_if.mem_addr_ok = 1'b1; #1;
    checks++; if (mem_if.mem_req !== 1'b1) begin failures++; $display("FAIL delay_accept_req got=%b exp=1", mem_if.mem_req); end
    cyc(); mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h1234_5678; #1;
    checks++; if (mem_if.mem_req !== 1'b0 || d_stall !== 1'b1) begin failures++; $display("FAIL delay_data_phase got req=%b stall=%b exp 0/1", mem_if.mem_req, d_stall); end
    cyc(); mem_if.mem_data_ok = 1'b0; #1;
    checks++; if (d_stall !== 1'b0 || data_rdata !== 32'h1234_5678 || mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL delay_done got stall=%b rdata=%h req=%b exp 0/12345678/0", d_stall, data_rdata, mem_if.mem_req); end
    cyc(); data_en = 1'b0; #1;
    checks++; if (mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL delay_single_req got=%b exp=0", mem_if.mem_req); end
  endtask

  task automatic test_flush();
    apply_reset();
    cyc(); data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h0000_3000; #1;
    cyc(); mem_if.mem_addr_ok = 1'b1; #1;
    checks++; if (mem_if.mem_req !== 1'b1) begin failures++; $display("FAIL flush_issue got=%b exp=1", mem_if.mem_req); end
    cyc(); mem_if.mem_addr_ok = 1'b0; flush = 1'b1; #1;
    checks++; if (d_stall !== 1'b1) begin failures++; $display("FAIL flush_c2_d got=%b exp=1", d_stall); end
    cyc(); flush = 1'b0; data_en = 1'b0; #1;
    checks++; if (i_stall !== 1'b1 || d_stall !== 1'b1 || mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL flush_kill got i=%b d=%b req=%b exp 1/1/0", i_stall, d_stall, mem_if.mem_req); end
    cyc(); mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'hAAAA_AAAA; #1;
    checks++; if (i_stall !== 1'b1 || d_stall !== 1'b1) begin failures++; $display("FAIL flush_drain got=%b%b exp=11", i_stall, d_stall); end
    cyc(); mem_if.mem_data_ok = 1'b0;
    inst_en = 1'b1; inst_addr = 32'hBFC0_0380; data_en = 1'b1; data_addr = 32'h0000_3000; #1;
    checks++; if (d_stall !== 1'b1 || i_stall !== 1'b1 || mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL flush_no_done got d=%b i=%b req=%b exp 1/1/0", d_stall, i_stall, mem_if.mem_req); end
    cyc(); #1;
    checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h0000_3000 || mem_if.mem_wr !== 1'b0) begin failures++; $display("FAIL flush_reissue got req=%b addr=%h wr=%b exp 1/00003000/0", mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wr); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_txn();
    apply_reset();
    cyc(); inst_en = 1'b1; inst_addr = 32'hBFC0_0000; #1;
    cyc(); mem_if.mem_addr_ok = 1'b1; #1;
    cyc(); mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h1111_2222; #1;
    cyc(); mem_if.mem_data_ok = 1'b0; #1;
    checks++; if (inst_rdata !== 32'h1111_2222) begin failures++; $display("FAIL rst_pre_rdata got=%h exp=11112222", inst_rdata); end
    cyc(); inst_addr = 32'hBFC0_0004; #1;
    cyc(); mem_if.mem_addr_ok = 1'b1; #1;
    checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== FETCH_PA4) begin failures++; $display("FAIL rst_second_issue got req=%b addr=%h exp 1/%h", mem_if.mem_req, mem_if.mem_addr, FETCH_PA4); end
    cyc(); mem_if.mem_addr_ok = 1'b0; rst_n = 1'b0; #1;
    checks++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 32'h0 || inst_rdata !== 32'h0) begin failures++; $display("FAIL rst_async got req=%b addr=%h rdata=%h exp 0/0/0", mem_if.mem_req, mem_if.mem_addr, inst_rdata); end
    checks++; if (i_stall !== 1'b1) begin failures++; $display("FAIL rst_i_stall got=%b exp=1", i_stall); end
    inst_en = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc(); mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'h9999_9999; inst_en = 1'b1; inst_addr = 32'hBFC0_0000; #1;
    checks++; if (i_stall !== 1'b1) begin failures++; $display("FAIL rst_stale_stall got=%b exp=1", i_stall); end
    cyc(); mem_if.mem_data_ok = 1'b0; #1;
    checks++; if (mem_if.mem_req !== 1'b1 || inst_rdata !== 32'h0 || i_stall !== 1'b1) begin failures++; $display("FAIL rst_stale_ignored got req=%b rdata=%h stall=%b exp 1/0/1", mem_if.mem_req, inst_rdata, i_stall); end
    idle_inputs();
  endtask

  task automatic test_inst_first();
    apply_reset();
    cyc();
    inst_en = 1'b1; inst_addr = 32'hBFC0_0000;
    data_en = 1'b1; data_wen = 4'hF; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF; #1;
    cyc(); mem_if2.mem_addr_ok = 1'b1; #1;
    checks++; if (mem_if2.mem_req !== 1'b1 || mem_if2.mem_wr !== 1'b0 || mem_if2.mem_addr !== FETCH_PA) begin failures++; $display("FAIL ifirst_issue got req=%b wr=%b addr=%h exp 1/0/%h", mem_if2.mem_req, mem_if2.mem_wr, mem_if2.mem_addr, FETCH_PA); end
    cyc(); mem_if2.mem_addr_ok = 1'b0; mem_if2.mem_data_ok = 1'b1; mem_if2.mem_rdata = 32'h2401_0001; #1;
    cyc(); mem_if2.mem_data_ok = 1'b0; #1;
    checks++; if (i_stall2 !== 1'b0 || d_stall2 !== 1'b1 || inst_rdata2 !== 32'h2401_0001) begin failures++; $display("FAIL ifirst_done got i=%b d=%b rdata=%h exp 0/1/24010001", i_stall2, d_stall2, inst_rdata2); end
    cyc(); #1;
    checks++; if (mem_if2.mem_req !== 1'b1 || mem_if2.mem_wr !== 1'b1 || mem_if2.mem_addr !== STORE_PA) begin failures++; $display("FAIL ifirst_store got req=%b wr=%b addr=%h exp 1/1/%h", mem_if2.mem_req, mem_if2.mem_wr, mem_if2.mem_addr, STORE_PA); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    test_reset();
    test_single_fetch();
    test_both_pending();
    test_addr_ok_delay();
    test_flush();
    test_reset_mid_txn();
    test_inst_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
